led_shift_driver: RTL and testbench

Downstream consumer of the 8-bit `leds` vector produced by the LED animation block. It serialises that pattern into an external 74HC595-style shift register, using data, shift clock, latch and active-low output-enable. It retransmits only when the pattern changes. It also dims the LEDs by PWM on the output-enable pin.

---
 rtl/led_shift_driver.sv | 156 +++++++++++++++
 tb/tb_led_shift_driver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/led_shift_driver.sv
// rtl/led_shift_driver.sv - serialises an LED pattern into a 74HC595-style shift register with PWM dimming
//
// Sends the upstream `leds` pattern MSB first over sr_data/sr_clk, pulses
// sr_latch, and dims the latched LEDs by PWM on sr_oe_n. A transfer only
// happens after reset or when the pattern differs from the last one sent.
//
// Parameters:
//   WIDTH      LED bits per transfer (>= 2)
//   CLK_DIV    clocks per sr_clk half-period and latch pulse width (>= 1)
//   PWM_BITS   width of brightness and of the PWM counter
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   leds        in   [WIDTH]    pattern from upstream
//   brightness  in   [PWM_BITS] duty setting, 0 = off
//   sr_data     out  serial data, valid across each SHIFT_LO/SHIFT_HI pair
//   sr_clk      out  shift clock, register samples on its rising edge
//   sr_latch    out  storage-register latch pulse, active high
//   sr_oe_n     out  output enable, active low (PWM)
//   busy        out  high while a transfer is in progress

module led_shift_driver #(
  parameter int WIDTH    = 8,
  parameter int CLK_DIV  = 4,
  parameter int PWM_BITS = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    leds,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                sr_data,
  output logic                sr_clk,
  output logic                sr_latch,
  output logic                sr_oe_n,
  output logic                busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t              state, state_nx;
  logic [WIDTH-1:0]    last, last_nx;
  logic                dirty, dirty_nx;
  // The MSB goes straight onto sr_data at start, so only the remaining
  // WIDTH-1 bits need to be held in flight.
  logic [WIDTH-2:0]    shreg, shreg_nx;
  logic [BIT_W-1:0]    bit_cnt, bit_nx;
  logic [DIV_W-1:0]    div_cnt, div_nx;
  logic                shown, shown_nx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                data_nx, clk_nx, latch_nx;

  always_comb begin
    state_nx = state;
    last_nx  = last;
    dirty_nx = dirty;
    shreg_nx = shreg;
    bit_nx   = bit_cnt;
    div_nx   = div_cnt;
    shown_nx = shown;
    data_nx  = sr_data;
    clk_nx   = sr_clk;
    latch_nx = sr_latch;
    case (state)
      IDLE: begin
        if (dirty || (leds != last)) begin
          state_nx = SHIFT_LO;
          shreg_nx = leds[WIDTH-2:0];
          last_nx  = leds;
          dirty_nx = 1'b0;
          data_nx  = leds[WIDTH-1];
          bit_nx   = '0;
          div_nx   = '0;
          clk_nx   = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (div_cnt == DIV_LAST) begin
          div_nx   = '0;
          clk_nx   = 1'b1;
          state_nx = SHIFT_HI;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_cnt == DIV_LAST) begin
          div_nx = '0;
          clk_nx = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            state_nx = LATCH;
            latch_nx = 1'b1;
          end else begin
            // Data only moves together with the falling sr_clk, so it is
            // stable across the whole low/high pair of each bit.
            state_nx = SHIFT_LO;
            data_nx  = shreg[WIDTH-2];
            shreg_nx = shreg << 1;
            bit_nx   = bit_cnt + 1'b1;
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (div_cnt == DIV_LAST) begin
          div_nx   = '0;
          latch_nx = 1'b0;
          shown_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last     <= '0;
      dirty    <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      shown    <= 1'b0;
      pwm_cnt  <= '0;
      sr_data  <= 1'b0;
      sr_clk   <= 1'b0;
      sr_latch <= 1'b0;
      sr_oe_n  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      dirty    <= dirty_nx;
      shreg    <= shreg_nx;
      bit_cnt  <= bit_nx;
      div_cnt  <= div_nx;
      shown    <= shown_nx;
      pwm_cnt  <= pwm_cnt + 1'b1;
      sr_data  <= data_nx;
      sr_clk   <= clk_nx;
      sr_latch <= latch_nx;
      // Outputs stay dark until a pattern has actually been latched.
      sr_oe_n  <= !(shown && (pwm_cnt < brightness));
      busy     <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_led_shift_driver.sv
// tb/tb_led_shift_driver.sv - randomized self-checking bench for led_shift_driver

module tb_led_shift_driver;

  localparam int WIDTH    = 8;
  localparam int CLK_DIV  = 4;
  localparam int PWM_BITS = 4;
  localparam int SHIFT_CYC = 2 * WIDTH * CLK_DIV;
  localparam int XFER      = SHIFT_CYC + CLK_DIV;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [WIDTH-1:0]    leds = '0;
  logic [PWM_BITS-1:0] brightness = '0;
  logic sr_data, sr_clk, sr_latch, sr_oe_n, busy;

  led_shift_driver #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .PWM_BITS(PWM_BITS)) dut (
    .clock(clock), .reset_n(reset_n), .leds(leds), .brightness(brightness),
    .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch),
    .sr_oe_n(sr_oe_n), .busy(busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: edges since reset release, transfer start
  // edge, and output waveform derived from the offset within a transfer.
  int               n, m_start;
  bit               m_active, m_dirty, m_shown;
  logic [WIDTH-1:0] m_last, m_pat;
  logic             e_data, e_clk, e_latch, e_oe_n, e_busy;
  logic [WIDTH-1:0] sent_q[$];

  task automatic model_edge();
    int c;
    if (!reset_n) begin
      n = 0; m_active = 0; m_dirty = 1; m_shown = 0; m_last = '0;
      e_data = 0; e_clk = 0; e_latch = 0; e_oe_n = 1; e_busy = 0;
    end else begin
      n++;
      e_oe_n = !(m_shown && (((n - 1) % (1 << PWM_BITS)) < int'(brightness)));
      if (m_active && (n - m_start == XFER)) begin
        m_active = 0; m_shown = 1;
        e_busy = 0; e_clk = 0; e_latch = 0;
        sent_q.push_back(m_pat);
      end else if (!m_active && (m_dirty || leds != m_last)) begin
        m_active = 1; m_start = n; m_pat = leds; m_last = leds; m_dirty = 0;
      end
      if (m_active) begin
        c = n - m_start;
        e_busy = 1;
        if (c < SHIFT_CYC) begin
          e_clk   = ((c / CLK_DIV) % 2) == 1;
          e_latch = 0;
          e_data  = m_pat[WIDTH - 1 - c / (2 * CLK_DIV)];
        end else begin
          e_clk = 0; e_latch = 1;
        end
      end
    end
  endtask

  // Behaves like the external 595: sample on sr_clk rise, store on latch rise.
  logic [WIDTH-1:0] cap_sr = '0;
  logic [WIDTH-1:0] cap_q[$];
  logic             p_clk = 0, p_latch = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      cap_sr = '0;
    end else begin
      if (sr_clk && !p_clk) cap_sr = {cap_sr[WIDTH-2:0], sr_data};
      if (sr_latch && !p_latch) cap_q.push_back(cap_sr);
    end
    p_clk   = sr_clk;
    p_latch = sr_latch;
  end

  int   c_busy, c_oe_low, c_latch, c_rise;
  logic t_prev_clk = 0;

  task automatic zero_counts();
    c_busy = 0; c_oe_low = 0; c_latch = 0; c_rise = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("cycle{busy,clk,latch,oe_n,data}",
          {busy, sr_clk, sr_latch, sr_oe_n, sr_data},
          {e_busy, e_clk, e_latch, e_oe_n, e_data});
    c_busy   += int'(busy);
    c_oe_low += int'(!sr_oe_n);
    c_latch  += int'(sr_latch);
    c_rise   += int'(sr_clk && !t_prev_clk);
    t_prev_clk = sr_clk;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ticks(3);
    reset_n = 1'b1;
  endtask

  int base;

  initial begin
    zero_counts();
    // Reset, all-off pattern, full brightness
    leds = 8'h00; brightness = 4'd15;
    base = cap_q.size();
    do_reset();
    zero_counts();
    ticks(150);
    check("rst_busy_cycles", c_busy, XFER);
    check("rst_cap_count", cap_q.size(), base + 1);
    check("rst_cap_value", cap_q[base], 8'h00);
    zero_counts();
    ticks(160);
    check("pwm15_low_cycles", c_oe_low, 150);
    check("idle_busy_cycles", c_busy, 0);

    // 0xA5 bit order and latch width
    leds = 8'hA5;
    base = cap_q.size();
    do_reset();
    zero_counts();
    ticks(100);
    check("a5_cap_value", cap_q[base], 8'hA5);
    check("a5_clk_rises", c_rise, WIDTH);
    check("a5_latch_cycles", c_latch, CLK_DIV);

    // Constant pattern: bus must stay quiet
    zero_counts();
    ticks(1000);
    check("quiet_clk_rises", c_rise, 0);
    check("quiet_latch_cycles", c_latch, 0);

    // Changes during a transfer: last value in IDLE wins
    base = cap_q.size();
    leds = 8'h01; ticks(10);
    leds = 8'h3C; ticks(20);
    leds = 8'hFF; ticks(150);
    check("skip_cap_count", cap_q.size(), base + 2);
    check("skip_cap_first", cap_q[base], 8'h01);
    check("skip_cap_second", cap_q[base + 1], 8'hFF);

    // Brightness extremes and midpoint
    brightness = 4'd0; ticks(2);
    zero_counts(); ticks(64);
    check("pwm0_low_cycles", c_oe_low, 0);
    brightness = 4'd8; ticks(2);
    zero_counts(); ticks(64);
    check("pwm8_low_cycles", c_oe_low, 32);

    // Reset in the middle of bit 4, then full resend of the same pattern
    leds = 8'h5A;
    ticks(1 + 34);
    check("midrst_busy_before", busy, 1'b1);
    base = cap_q.size();
    do_reset();
    zero_counts();
    ticks(150);
    check("midrst_busy_cycles", c_busy, XFER);
    check("midrst_cap_count", cap_q.size(), base + 1);
    check("midrst_cap_value", cap_q[base], 8'h5A);
    check("midrst_latch_cycles", c_latch, CLK_DIV);

    // Random patterns, hold times and brightness
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) leds = WIDTH'($urandom);
      brightness = PWM_BITS'($urandom);
      ticks($urandom_range(1, 120));
    end
    ticks(200);

    check("total_transfers", cap_q.size(), sent_q.size());
    for (int i = 0; i < cap_q.size() && i < sent_q.size(); i++)
      check("transfer_value", cap_q[i], sent_q[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
